// File: rtl/prim_ram_2p_fifo.sv
// FIFO controller for an external 2-port RAM (port A writes, port B reads), with a
// 2-entry prefetch buffer that hides the RAM's 1-cycle read latency.
module prim_ram_2p_fifo #(
  parameter  int Width = 32,
  parameter  int Depth = 128,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [Aw+1:0]    depth_o,
  output logic             ram_a_req_o,
  output logic             ram_a_write_o,
  output logic [Aw-1:0]    ram_a_addr_o,
  output logic [Width-1:0] ram_a_wdata_o,
  output logic             ram_b_req_o,
  output logic             ram_b_write_o,
  output logic [Aw-1:0]    ram_b_addr_o,
  output logic [Width-1:0] ram_b_wdata_o,
  input  logic [Width-1:0] ram_b_rdata_i
);

  localparam logic [Aw:0] FullCnt = (Aw+1)'(Depth);

  logic [Aw:0]      wr_ptr_r, rd_ptr_r, ram_cnt_s;
  logic             pend_r;
  logic [1:0]       buf_cnt_r;
  logic             buf_rd_r, buf_wr_r;
  logic [Width-1:0] buf_mem_r [2];
  logic             push_s, pop_s, issue_s;
  logic [2:0]       occ_s;

  assign ram_cnt_s = wr_ptr_r - rd_ptr_r;

  // Handshakes, read-issue decision and RAM port drive
  always_comb begin
    wready_o      = (ram_cnt_s != FullCnt);
    push_s        = wvalid_i & wready_o;
    rvalid_o      = (buf_cnt_r != 2'd0);
    pop_s         = rvalid_o & rready_i;
    rdata_o       = buf_mem_r[buf_rd_r];
    // Words already committed to the buffer once the pending return lands
    occ_s         = {1'b0, buf_cnt_r} + {2'b00, pend_r} - {2'b00, pop_s};
    issue_s       = (ram_cnt_s != {(Aw+1){1'b0}}) & (occ_s < 3'd2);
    ram_a_req_o   = push_s;
    ram_a_write_o = push_s;
    ram_a_addr_o  = wr_ptr_r[Aw-1:0];
    ram_a_wdata_o = wdata_i;
    ram_b_req_o   = issue_s;
    ram_b_write_o = 1'b0;
    ram_b_addr_o  = rd_ptr_r[Aw-1:0];
    ram_b_wdata_o = {Width{1'b0}};
    depth_o       = {1'b0, ram_cnt_s} + {{(Aw+1){1'b0}}, pend_r} + {{Aw{1'b0}}, buf_cnt_r};
  end

  // Pointer, pending-read and buffer occupancy state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r  <= {(Aw+1){1'b0}};
      rd_ptr_r  <= {(Aw+1){1'b0}};
      pend_r    <= 1'b0;
      buf_cnt_r <= 2'd0;
      buf_rd_r  <= 1'b0;
      buf_wr_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{Aw{1'b0}}, 1'b1};
      if (issue_s) rd_ptr_r <= rd_ptr_r + {{Aw{1'b0}}, 1'b1};
      pend_r    <= issue_s;
      if (pend_r) buf_wr_r <= ~buf_wr_r;
      if (pop_s) buf_rd_r <= ~buf_rd_r;
      buf_cnt_r <= buf_cnt_r + {1'b0, pend_r} - {1'b0, pop_s};
    end
  end

  // Capture returning RAM data; a return landing on a reset edge is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i && pend_r) begin
      buf_mem_r[buf_wr_r] <= ram_b_rdata_i;
    end
  end

endmodule

// File: tb/tb_prim_ram_2p_fifo.sv
// Bench for prim_ram_2p_fifo: a Depth=4 instance driven from a vector table and a
// reset sequence, and a Depth=8 instance for streaming and random scoreboard runs.
module tb_prim_ram_2p_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Depth=4 instance signals
  logic        w4_valid = 1'b0, r4_ready = 1'b0;
  logic [31:0] w4_data = 32'd0;
  logic        w4_ready, r4_valid;
  logic [31:0] r4_data;
  logic [3:0]  d4_depth;
  logic        a4_req, a4_write, b4_req, b4_write;
  logic [1:0]  a4_addr, b4_addr;
  logic [31:0] a4_wdata, b4_wdata, b4_rdata;
  logic [31:0] mem4 [4];

  // Depth=8 instance signals
  logic        w8_valid = 1'b0, r8_ready = 1'b0;
  logic [31:0] w8_data = 32'd0;
  logic        w8_ready, r8_valid;
  logic [31:0] r8_data;
  logic [4:0]  d8_depth;
  logic        a8_req, a8_write, b8_req, b8_write;
  logic [2:0]  a8_addr, b8_addr;
  logic [31:0] a8_wdata, b8_wdata, b8_rdata;
  logic [31:0] mem8 [8];

  prim_ram_2p_fifo #(.Width(32), .Depth(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .wvalid_i(w4_valid), .wready_o(w4_ready), .wdata_i(w4_data),
    .rvalid_o(r4_valid), .rready_i(r4_ready), .rdata_o(r4_data),
    .depth_o(d4_depth),
    .ram_a_req_o(a4_req), .ram_a_write_o(a4_write), .ram_a_addr_o(a4_addr), .ram_a_wdata_o(a4_wdata),
    .ram_b_req_o(b4_req), .ram_b_write_o(b4_write), .ram_b_addr_o(b4_addr), .ram_b_wdata_o(b4_wdata),
    .ram_b_rdata_i(b4_rdata)
  );

  prim_ram_2p_fifo #(.Width(32), .Depth(8)) dut8 (
    .clk_i(clk), .rst_i(rst),
    .wvalid_i(w8_valid), .wready_o(w8_ready), .wdata_i(w8_data),
    .rvalid_o(r8_valid), .rready_i(r8_ready), .rdata_o(r8_data),
    .depth_o(d8_depth),
    .ram_a_req_o(a8_req), .ram_a_write_o(a8_write), .ram_a_addr_o(a8_addr), .ram_a_wdata_o(a8_wdata),
    .ram_b_req_o(b8_req), .ram_b_write_o(b8_write), .ram_b_addr_o(b8_addr), .ram_b_wdata_o(b8_wdata),
    .ram_b_rdata_i(b8_rdata)
  );

  // Behavioural 2-port RAMs with 1-cycle read latency
  always @(posedge clk) begin
    if (a4_req && a4_write) mem4[a4_addr] <= a4_wdata;
    if (b4_req) b4_rdata <= mem4[b4_addr];
    if (a8_req && a8_write) mem8[a8_addr] <= a8_wdata;
    if (b8_req) b8_rdata <= mem8[b8_addr];
  end

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        e_wr;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [7:0]  e_dp;
    logic        e_areq;
    logic        e_breq;
  } vec_t;

  vec_t vecs [$];
  logic [31:0] sb [$];

  function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic rr,
                              input logic e_wr, input logic e_rv, input logic [31:0] e_rd,
                              input logic [7:0] e_dp, input logic e_areq, input logic e_breq);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.e_wr = e_wr; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_dp = e_dp; v.e_areq = e_areq; v.e_breq = e_breq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_n;
    int mcount;
    logic [31:0] front;

    // Single write through to read-out, latency 3
    vecs.push_back(mk(1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0, 8'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'd1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 8'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0));
    // Fill to Depth+2 with consumer stalled, writes 6..9 rejected
    vecs.push_back(mk(1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0, 8'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 32'd0, 8'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd0, 8'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd0, 8'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 32'd0, 8'd5, 1'b1, 1'b0));
    for (int i = 6; i < 10; i++)
      vecs.push_back(mk(1'b1, i, 1'b0, 1'b0, 1'b1, 32'd0, 8'd6, 1'b0, 1'b0));
    // Drain all six in order
    vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, 8'd6, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd1, 8'd5, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd2, 8'd4, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3, 8'd3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4, 8'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd5, 8'd1, 1'b0, 1'b0));
    // Empty with consumer ready: nothing moves
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0));

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst4_wready", w4_ready, 1);
    chk("rst4_rvalid", r4_valid, 0);
    chk("rst4_depth", d4_depth, 0);
    chk("rst4_reqs", {a4_req, a4_write, b4_req, b4_write}, 0);
    chk("rst4_bwdata", b4_wdata, 0);
    chk("rst8_wready", w8_ready, 1);
    chk("rst8_rvalid", r8_valid, 0);
    chk("rst8_depth", d8_depth, 0);
    chk("rst8_reqs", {a8_req, a8_write, b8_req, b8_write}, 0);
    tick();

    foreach (vecs[i]) begin
      w4_valid = vecs[i].wv;
      w4_data  = vecs[i].wd;
      r4_ready = vecs[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d_wready", i), w4_ready, vecs[i].e_wr);
      chk($sformatf("v%0d_rvalid", i), r4_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("v%0d_rdata", i), r4_data, vecs[i].e_rd);
      chk($sformatf("v%0d_depth", i), d4_depth, vecs[i].e_dp);
      chk($sformatf("v%0d_areq", i), a4_req, vecs[i].e_areq);
      chk($sformatf("v%0d_breq", i), b4_req, vecs[i].e_breq);
      tick();
    end

    // Reset while a RAM read is in flight
    r4_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w4_valid = 1'b1;
      w4_data  = 32'h100 + i;
      tick();
    end
    w4_valid = 1'b0;
    r4_ready = 1'b1;
    @(negedge clk);
    chk("rp_issue", b4_req, 1);
    tick();
    r4_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w4_valid = 1'b1;
    w4_data  = 32'h1234;
    r4_ready = 1'b1;
    @(negedge clk);
    chk("rp_rvalid", r4_valid, 0);
    chk("rp_depth", d4_depth, 0);
    chk("rp_wready", w4_ready, 1);
    tick();
    w4_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (r4_valid && lat == 0) begin
        lat = c;
        chk("rp_first_word", r4_data, 32'h1234);
      end
      tick();
      if (lat != 0) break;
    end
    chk("rp_latency", lat, 3);
    @(negedge clk);
    chk("rp_after_rvalid", r4_valid, 0);
    chk("rp_after_depth", d4_depth, 0);
    tick();
    r4_ready = 1'b0;

    // Continuous push and pop on Depth=8
    exp_n = 0;
    for (int c = 0; c < 40; c++) begin
      w8_valid = 1'b1;
      w8_data  = 32'hC000_0000 + c;
      r8_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("st%0d_wready", c), w8_ready, 1);
      chk($sformatf("st%0d_rvalid", c), r8_valid, (c >= 3) ? 1 : 0);
      if (r8_valid) begin
        chk($sformatf("st%0d_rdata", c), r8_data, 32'hC000_0000 + exp_n);
        exp_n++;
      end
      tick();
    end
    w8_valid = 1'b0;
    for (int c = 0; c < 10 && exp_n < 40; c++) begin
      @(negedge clk);
      if (r8_valid) begin
        chk("st_drain_rdata", r8_data, 32'hC000_0000 + exp_n);
        exp_n++;
      end
      tick();
    end
    chk("st_total", exp_n, 40);
    @(negedge clk);
    chk("st_end_depth", d8_depth, 0);
    tick();

    // Random valid/ready with scoreboard on Depth=8
    mcount = 0;
    for (int c = 0; c < 2000; c++) begin
      w8_valid = 1'($urandom_range(0, 1));
      r8_ready = 1'($urandom_range(0, 1));
      w8_data  = $urandom;
      @(negedge clk);
      chk("rnd_depth", d8_depth, mcount);
      if (a8_req && b8_req) chk("rnd_collision", (a8_addr != b8_addr), 1);
      if (w8_valid && w8_ready) begin
        sb.push_back(w8_data);
        mcount++;
      end
      if (r8_valid && r8_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_spurious_pop", 1, 0);
        end else begin
          front = sb.pop_front();
          chk("rnd_rdata", r8_data, front);
          mcount--;
        end
      end
      tick();
    end
    w8_valid = 1'b0;
    r8_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (r8_valid) begin
        front = sb.pop_front();
        chk("rnd_drain_rdata", r8_data, front);
      end
      tick();
    end
    chk("rnd_left", sb.size(), 0);
    @(negedge clk);
    chk("rnd_end_depth", d8_depth, 0);
    chk("rnd_end_rvalid", r8_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prim_ram_2p_fifo.md
Name: prim_ram_2p_fifo

Overview:
- Synchronous FIFO controller that drives one 2-port RAM instance directly: port A is write-only, port B is read-only.
- Converts valid/ready write and read streams into RAM req/write/addr traffic.
- Absorbs the RAM's 1-cycle read latency with a 2-entry output prefetch buffer, giving 1 word/cycle sustained throughput.
- Sits directly upstream of the RAM; the parent wires the ram_* ports straight onto it.

Parameters:
- Width, 32, data word width; must match the attached RAM.
- Depth, 128, RAM entries; power of two, >= 4.
- Aw, $clog2(Depth), RAM address width (localparam).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- wvalid_i  in  1  write request
- wready_o  out  1  FIFO can accept a write
- wdata_i  in  Width  write data
- rvalid_o  out  1  rdata_o holds valid head word
- rready_i  in  1  consumer takes head word
- rdata_o  out  Width  head word
- depth_o  out  Aw+2  total words held (RAM + in flight + buffer)
- ram_a_req_o  out  1  RAM port A request
- ram_a_write_o  out  1  RAM port A write enable
- ram_a_addr_o  out  Aw  RAM port A address
- ram_a_wdata_o  out  Width  RAM port A write data
- ram_b_req_o  out  1  RAM port B request
- ram_b_write_o  out  1  constant 0
- ram_b_addr_o  out  Aw  RAM port B address
- ram_b_wdata_o  out  Width  constant 0
- ram_b_rdata_i  in  Width  RAM port B read data, valid 1 cycle after ram_b_req_o

Behaviour:
- State:
  - wr_ptr, rd_ptr: Aw+1 bits each; MSB is the wrap bit.
  - ram_cnt = wr_ptr - rd_ptr, modulo 2^(Aw+1), range 0..Depth.
  - pend: 1 bit; a RAM read was issued last cycle.
  - buf: 2-entry FIFO of Width with buf_cnt 0..2.
- Reset:
  - While rst_i is high at a clock edge: pointers, pend, buf_cnt cleared to 0.
  - Outputs from the first cycle after reset: wready_o=1, rvalid_o=0, depth_o=0, all ram req outputs 0.
  - RAM contents are not cleared.
  - A reset mid-operation discards all stored and in-flight data; RAM data returning the cycle after reset is dropped.
- Write:
  - wready_o = (ram_cnt != Depth).
  - Push = wvalid_i & wready_o.
  - On push: ram_a_req_o = 1 and ram_a_write_o = 1, same cycle, combinational; ram_a_addr_o = wr_ptr[Aw-1:0]; ram_a_wdata_o = wdata_i; wr_ptr increments at the clock edge.
  - When there is no push: ram_a_req_o = 0, ram_a_write_o = 0.
- Pop: pop = rvalid_o & rready_i. rvalid_o = (buf_cnt != 0). rdata_o = buf head.
- Read issue:
  - Condition: issue = (ram_cnt != 0) & ((buf_cnt + pend - pop) < 2).
  - On issue: ram_b_req_o = 1 and ram_b_addr_o = rd_ptr[Aw-1:0]; rd_ptr increments and pend is set for the next cycle.
  - ram_b_req_o = 0 otherwise.
- Return: when pend = 1, ram_b_rdata_i is written into the buf tail at that cycle's edge.
- Simultaneous return and pop: the write and the pop happen in the same cycle; buf_cnt is unchanged.
- Read/write collision: a read never targets the address written in the same cycle. Reads require ram_cnt > 0 from registered pointers, and writes require ram_cnt < Depth, so the two addresses always differ.
- Latency: a write accepted in cycle 0 on an empty FIFO gives read issue in cycle 1, RAM data in cycle 2, and rvalid_o high in cycle 3.
- Throughput: with continuous push and pop, steady state is buf_cnt=1, pend=1 and 1 word/cycle both sides.
- Capacity: Depth + 2 words, since the buffer drains up to 2 words out of the RAM.
- depth_o = ram_cnt + pend + buf_cnt, registered-state sum; no combinational path from wvalid_i or rready_i.
- Pointer wrap: the address uses the low Aw bits and the MSB toggles. Full/empty are distinguished by the MSB, so there is no off-by-one at the wrap boundary.
- Ordering: output order equals write order under any valid/ready pattern; no word is lost or duplicated.

Test Plan:
- Depth=4, single write 0xA5A5_0001 in cycle 0, rready_i=1 -> ram_b_req_o in cycle 1, rvalid_o=1 with rdata_o=0xA5A5_0001 in cycle 3, depth_o back to 0 in cycle 4.
- Depth=4, rready_i=0, write 0..9 continuously -> exactly 6 writes accepted; wready_o=0 after the 6th; depth_o=6; then pop all -> 0..5 in order, depth_o=0, wready_o=1.
- Depth=8, wvalid_i and rready_i held high for 40 cycles, incrementing data -> after the fill latency one pop per cycle, data sequential; pointers wrap 5 times; no gaps.
- Random wvalid_i/rready_i (50%) for 2000 cycles, Depth=8 -> scoreboard order matches; depth_o always equals pushes minus pops; no read/write address collision on the RAM ports.
- Fill 5 words, assert rst_i for 1 cycle while a RAM read is pending -> next cycle rvalid_o=0, depth_o=0, wready_o=1; the stale return is not buffered; a new write 0x1234 emerges as the first word.
- Empty FIFO, rready_i=1 held, no writes -> ram_b_req_o stays 0; rvalid_o stays 0; depth_o stays 0.
